// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matmul_pkg
// Purpose  : Shared constants and helpers for the matmul job arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_GRANT   = 3'd1;
    localparam logic [2:0] c_ST_RUN     = 3'd2;
    localparam logic [2:0] c_ST_RELEASE = 3'd3;
    localparam logic [2:0] c_ST_ABORT   = 3'd4;

    localparam int c_DIM_W_DEFAULT = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : matmul_rr_pick
// Purpose  : Combinational round-robin picker: first set request at or above
//            rr_ptr, wrapping modulo NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               any,
    output logic [PTR_W-1:0]   winner
);

    int w_idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        w_idx  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = int'(rr_ptr) + i;
            // explicit wrap keeps non-power-of-two requester counts correct
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!any && req[w_idx]) begin
                any    = 1'b1;
                winner = PTR_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/matmul_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : matmul_job_arbiter
// Purpose  : Round-robin owner of a shared matrix-multiply engine with start,
//            completion return and watchdog abort.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_job_arbiter
    import matmul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DIM_W   = c_DIM_W_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DIM_W-1:0]   req_rows,
    input  logic [NUM_REQ*DIM_W-1:0]   req_cols,
    input  logic [NUM_REQ*DIM_W-1:0]   req_k,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    output logic                       busy,
    output logic [clog2(NUM_REQ)-1:0]  owner,
    output logic                       eng_start,
    output logic [DIM_W-1:0]           eng_rows,
    output logic [DIM_W-1:0]           eng_cols,
    output logic [DIM_W-1:0]           eng_k,
    input  logic                       eng_done,
    output logic                       eng_abort
);

    localparam int c_PTR_W = clog2(NUM_REQ);
    localparam int c_TMR_W = clog2(TIMEOUT);

    logic [2:0]          r_state;
    logic [c_PTR_W-1:0]  r_rr_ptr;
    logic [c_PTR_W-1:0]  r_owner;
    logic [c_TMR_W-1:0]  r_timer;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic [NUM_REQ-1:0]  r_err;
    logic                r_busy;
    logic                r_start;
    logic                r_abort;
    logic [DIM_W-1:0]    r_rows;
    logic [DIM_W-1:0]    r_cols;
    logic [DIM_W-1:0]    r_k;

    logic                w_any;
    logic [c_PTR_W-1:0]  w_winner;
    logic [NUM_REQ-1:0]  w_win_hot;
    logic [NUM_REQ-1:0]  w_owner_hot;
    logic [c_PTR_W-1:0]  w_next_ptr;
    logic                w_timeout;

    matmul_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_pick (
        .req     (req),
        .rr_ptr  (r_rr_ptr),
        .any     (w_any),
        .winner  (w_winner)
    );

    assign w_win_hot   = NUM_REQ'(1) << w_winner;
    assign w_owner_hot = NUM_REQ'(1) << r_owner;
    assign w_next_ptr  = (r_owner == c_PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + c_PTR_W'(1);
    assign w_timeout   = (r_timer == c_TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_timer  <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_busy   <= 1'b0;
            r_start  <= 1'b0;
            r_abort  <= 1'b0;
            r_rows   <= '0;
            r_cols   <= '0;
            r_k      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_state <= c_ST_GRANT;
                        r_gnt   <= w_win_hot;
                        r_owner <= w_winner;
                        r_busy  <= 1'b1;
                        r_start <= 1'b1;
                        r_rows  <= req_rows[w_winner*DIM_W +: DIM_W];
                        r_cols  <= req_cols[w_winner*DIM_W +: DIM_W];
                        r_k     <= req_k[w_winner*DIM_W +: DIM_W];
                    end
                end
                c_ST_GRANT: begin
                    r_state <= c_ST_RUN;
                    r_start <= 1'b0;
                    r_timer <= '0;
                end
                c_ST_RUN: begin
                    // completion takes priority over a coincident timeout
                    if (eng_done) begin
                        r_state <= c_ST_RELEASE;
                        r_done  <= w_owner_hot;
                    end else if (w_timeout) begin
                        r_state <= c_ST_ABORT;
                        r_err   <= w_owner_hot;
                        r_abort <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                c_ST_RELEASE, c_ST_ABORT: begin
                    r_state  <= c_ST_IDLE;
                    r_rr_ptr <= w_next_ptr;
                    r_gnt    <= '0;
                    r_owner  <= '0;
                    r_busy   <= 1'b0;
                    r_done   <= '0;
                    r_err    <= '0;
                    r_abort  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_gnt   <= '0;
                    r_owner <= '0;
                    r_busy  <= 1'b0;
                    r_start <= 1'b0;
                    r_done  <= '0;
                    r_err   <= '0;
                    r_abort <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign busy      = r_busy;
    assign owner     = r_owner;
    assign eng_start = r_start;
    assign eng_abort = r_abort;
    assign eng_rows  = r_rows;
    assign eng_cols  = r_cols;
    assign eng_k     = r_k;

endmodule
`default_nettype wire
